seg_scan_mux: RTL

//   Time-multiplexed scan controller for a common-anode multi-digit 7-segment display.

---
 rtl/seg_scan_mux_if.sv | 21 ++
 rtl/seg_scan_mux.sv | 96 +++++++++
 2 files changed

// File: rtl/seg_scan_mux_if.sv
// Bus bundle between a digit source and the seg_scan_mux display scanner.
interface seg_scan_mux_if #(
  parameter int NUM_DIGITS = 8
) ();
  logic [4*NUM_DIGITS-1:0] iDigits;
  logic [NUM_DIGITS-1:0]   iDigitEn;
  logic                    iBlankLZ;
  logic [3:0]              oDigit;
  logic [NUM_DIGITS-1:0]   oAn;
  logic                    oFrame;

  modport master (
    output iDigits, iDigitEn, iBlankLZ,
    input  oDigit, oAn, oFrame
  );

  modport slave (
    input  iDigits, iDigitEn, iBlankLZ,
    output oDigit, oAn, oFrame
  );
endinterface

// File: rtl/seg_scan_mux.sv
// Multi-digit 7-segment scan controller: frame-coherent snapshot of the
// BCD digits, per-digit enables, optional leading-zero blanking and a dead
// time at the start of every digit slot to suppress ghosting.
module seg_scan_mux #(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 100000,
  parameter int GHOST_CYC  = 1000
) (
  input logic          clk,
  input logic          rst,
  seg_scan_mux_if.slave bus
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [3:0]            shDig [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] shEn;

  logic                  tick;
  logic                  lastSlot;
  logic                  ghost;
  logic                  off;
  logic [NUM_DIGITS-1:0] zeroFromTop;
  logic [NUM_DIGITS-1:0] lzBlank;

  assign tick     = (cnt == CNT_MAX);
  assign lastSlot = (idx == IDX_MAX);

  // Dead time only exists when GHOST_CYC is nonzero; avoids an always-false compare.
  if (GHOST_CYC > 0) begin : gGhost
    assign ghost = (cnt < CW'(GHOST_CYC));
  end else begin : gNoGhost
    assign ghost = 1'b0;
  end

  // Leading-zero chain: digit k blanks when it and every digit above it are zero.
  always_comb begin
    zeroFromTop = '0;
    lzBlank     = '0;
    zeroFromTop[NUM_DIGITS-1] = (shDig[NUM_DIGITS-1] == 4'h0);
    for (int unsigned j = 1; j < NUM_DIGITS; j++) begin
      zeroFromTop[NUM_DIGITS-1-j] = zeroFromTop[NUM_DIGITS-j] &&
                                    (shDig[NUM_DIGITS-1-j] == 4'h0);
    end
    for (int unsigned k = 1; k < NUM_DIGITS; k++) begin
      lzBlank[k] = bus.iBlankLZ && zeroFromTop[k];
    end
  end

  // Current slot is dark during dead time, when disabled, or when LZ-blanked.
  always_comb begin
    off = ghost || !shEn[idx] || lzBlank[idx];
  end

  // Prescaler, slot index and end-of-frame input snapshot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      idx  <= '0;
      shEn <= '0;
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
        shDig[k] <= '0;
      end
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) begin
        idx <= lastSlot ? '0 : idx + 1'b1;
      end
      if (tick && lastSlot) begin
        shEn <= bus.iDigitEn;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
          shDig[k] <= bus.iDigits[4*k +: 4];
        end
      end
    end
  end

  // Registered display outputs, one cycle behind the scan state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.oAn    <= '1;
      bus.oDigit <= 4'hF;
      bus.oFrame <= 1'b0;
    end else begin
      bus.oAn    <= off ? '1 : ~(NUM_DIGITS'(1) << idx);
      bus.oDigit <= off ? 4'hF : shDig[idx];
      bus.oFrame <= tick && lastSlot;
    end
  end

endmodule
